decode_issue_buffer: RTL and testbench
======================================

Name: decode_issue_buffer

Overview:
- Parametrised decoded-op queue between the decode stage and the execution stage.
- Replaces the single-entry decode→execute posedge register with a DEPTH-entry FIFO that uses a valid/ready handshake.
- Adds a per-register scoreboard that holds back issue on RAW and WAW hazards against in-flight writes.
- Writes are cleared by the write-back port. The pipeline controller flushes the queue on branch mispredict, mret or exception.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2.
- XLEN, 32, program-counter width.
- PAYLOAD_W, 128, width of the opaque decoded control/immediate/operand bundle.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  decode presents an op.
- in_ready_o  out  1  buffer can accept; equals !full_o, registered-state only.
- in_pc_i  in  XLEN  program counter of the op.
- in_payload_i  in  PAYLOAD_W  decoded bundle, stored unmodified.
- in_rs1_i, in_rs2_i  in  5 each  source register indices.
- in_rs1_use_i, in_rs2_use_i  in  1 each  source is actually read.
- in_rd_i  in  5  destination register index.
- in_reg_write_i  in  1  op writes rd.
- out_valid_o  out  1  head entry is present and hazard-free.
- out_ready_i  in  1  execute accepts the head.
- out_pc_o  out  XLEN  head program counter.
- out_payload_o  out  PAYLOAD_W  head bundle.
- out_rd_o  out  5  head rd.
- out_reg_write_o  out  1  head reg_write.
- wb_write_i  in  1  write-back retires a register write.
- wb_rd_i  in  5  retiring rd.
- flush_i  in  1  pipeline-controller flush.
- count_o  out  CNT_W  occupancy.
- empty_o, full_o  out  1 each  status.
- hazard_stall_o  out  1  head held by scoreboard.

Behaviour:
- Reset (rst_i low, async):
  - Read/write pointers, count and all scoreboard bits clear to 0.
  - out_valid_o=0, empty_o=1, full_o=0, count_o=0, in_ready_o=1, hazard_stall_o=0.
  - Storage contents are don't-care; out_* data reads entry 0.
  - Reset asserted mid-operation discards all entries and all pending bits.
- Storage and pointers:
  - Storage is DEPTH entries of {pc, payload, rs1, rs2, rs1_use, rs2_use, rd, reg_write}.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Push: in_valid_i && in_ready_o. The entry is written at wptr and wptr increments.
- Pop: out_valid_o && out_ready_i. rptr increments.
- Latency: an op pushed in cycle N is visible on out_* in cycle N+1 at the earliest. There is no fall-through bypass.
- Occupancy:
  - count_o is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
  - When full, push is refused even if a pop happens the same cycle; in_ready_o carries no combinational path from out_ready_i.
- Hazard, evaluated on the head entry using pend_eff = pend & ~wb_clr_vec:
  - wb_clr_vec is the one-hot of wb_rd_i when wb_write_i=1.
  - hazard = (rs1_use && rs1≠0 && pend_eff[rs1]) || (rs2_use && rs2≠0 && pend_eff[rs2]) || (reg_write && rd≠0 && pend_eff[rd]).
  - out_valid_o = !empty && !hazard.
  - hazard_stall_o = !empty && hazard.
- Scoreboard update per cycle:
  - Clear bit wb_rd_i on write-back.
  - Then set bit rd on a pop with reg_write && rd≠0; set wins on the same index.
  - x0 is never marked pending.
- Flush:
  - flush_i empties the queue (rptr=wptr=0, count=0) and clears all scoreboard bits next cycle.
  - A push or pop in the same cycle is ignored.
  - The controller asserts flush_i only when every in-flight writer is squashed or already retired.
- Stall: out_ready_i=0 holds the head and all out_* stable. Decode backs up via in_ready_o once full.

Decomposition:
- Shared package decode_pkg: XLEN, REG_IDX_W=5, NUM_REGS=32, and the issue-entry struct typedef {pc, payload, rs1, rs2, rs1_use, rs2_use, rd, reg_write}.
- One sub-module: issue_scoreboard.
  - Inputs: head source/dest fields, issue set, wb clear, flush.
  - Outputs: hazard.
  - Holds the 32-bit pending vector.
- The FIFO stays in the top.

Test Plan:
- Fill/drain, DEPTH=4: push pc 0x100,0x104,0x108,0x10C with out_ready_i=0 → full_o=1, in_ready_o=0, count_o=4. Then out_ready_i=1 → pops in order over 4 cycles, empty_o=1 after the last.
- Wrap plus simultaneous push/pop: keep count at 2 while streaming 10 ops → count_o stays 2, order preserved across pointer wrap, no drop or duplicate.
- RAW: pop op A (rd=x5, reg_write=1), then head B uses rs1=x5 → hazard_stall_o=1, out_valid_o=0. Pulse wb_write_i with wb_rd_i=5 → B valid the same cycle.
- x0 and WAW: op writes x0 then op reads x0 → no stall. Op writes x7, next op also writes x7 → second held until wb of x7.
- Same-cycle set/clear: wb retires x3 while the popped head writes x3 → pend[3]=1 afterwards; a following reader of x3 stalls.
- Flush and reset: 3 entries queued with pend[9]=1, assert flush_i with in_valid_i=1 → next cycle count_o=0, pend all 0, pushed op not stored. Assert rst_i low mid-stream → outputs reach reset values immediately, without a clock edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the decode -> execute issue path.
package decode_pkg;

  localparam int XLEN      = 32;
  localparam int PAYLOAD_W = 128;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  // Default-width layout of one queued op; the top builds the same layout
  // from its own XLEN/PAYLOAD_W parameters so both stay overridable.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [PAYLOAD_W-1:0] payload;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs1_use;
    logic                 rs2_use;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
  } issue_entry_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register pending-write tracker. A bit is set when a writer issues and
// cleared when write-back retires it; the head op is held while any register
// it reads or writes is still pending.
module issue_scoreboard
  import decode_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic                 rs1_use_i,
  input  logic                 rs2_use_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 reg_write_i,
  input  logic                 issue_i,
  input  logic                 wb_write_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  output logic                 hazard_o
);

  logic [NUM_REGS-1:0] pend_reg;
  logic [NUM_REGS-1:0] pend_next;
  logic [NUM_REGS-1:0] wb_clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] pend_eff;

  // One-hot clear/set vectors; x0 is hardwired zero so it is never marked.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_vec
    assign wb_clr_vec[gi] = wb_write_i && (wb_rd_i == REG_IDX_W'(gi));
    if (gi == 0) begin : g_x0
      assign set_vec[gi] = 1'b0;
    end else begin : g_xn
      assign set_vec[gi] = issue_i && reg_write_i && (rd_i == REG_IDX_W'(gi));
    end
  end

  // A retiring write releases its dependants in the same cycle.
  assign pend_eff = pend_reg & ~wb_clr_vec;

  // Hazard check on the head op against the effective pending set.
  always_comb begin
    hazard_o = 1'b0;
    if (rs1_use_i && (rs1_i != '0) && pend_eff[rs1_i]) hazard_o = 1'b1;
    if (rs2_use_i && (rs2_i != '0) && pend_eff[rs2_i]) hazard_o = 1'b1;
    if (reg_write_i && (rd_i != '0) && pend_eff[rd_i]) hazard_o = 1'b1;
  end

  // Clear first, then set, so a new writer of the retiring register stays pending.
  always_comb begin
    pend_next = pend_eff | set_vec;
    if (flush_i) pend_next = '0;
  end

  // Pending-vector register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pend_reg <= '0;
    else        pend_reg <= pend_next;
  end

endmodule

// File: rtl/decode_issue_buffer.sv
// DEPTH-entry decoded-op queue between decode and execute with a valid/ready
// handshake on both sides and scoreboard-gated issue of the head entry.
module decode_issue_buffer
  import decode_pkg::*;
#(
  parameter  int DEPTH     = 4,
  parameter  int XLEN      = decode_pkg::XLEN,
  parameter  int PAYLOAD_W = decode_pkg::PAYLOAD_W,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [XLEN-1:0]      in_pc_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic [REG_IDX_W-1:0] in_rs1_i,
  input  logic [REG_IDX_W-1:0] in_rs2_i,
  input  logic                 in_rs1_use_i,
  input  logic                 in_rs2_use_i,
  input  logic [REG_IDX_W-1:0] in_rd_i,
  input  logic                 in_reg_write_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      out_pc_o,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [REG_IDX_W-1:0] out_rd_o,
  output logic                 out_reg_write_o,
  input  logic                 wb_write_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic                 flush_i,
  output logic [CNT_W-1:0]     count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 hazard_stall_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [PAYLOAD_W-1:0] payload;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs1_use;
    logic                 rs2_use;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           entry_in;
  entry_t           head;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop, hazard;

  assign entry_in = '{pc: in_pc_i, payload: in_payload_i, rs1: in_rs1_i, rs2: in_rs2_i,
                      rs1_use: in_rs1_use_i, rs2_use: in_rs2_use_i, rd: in_rd_i,
                      reg_write: in_reg_write_i};
  assign head     = mem[rptr_reg];

  // Status comes from registered occupancy only, so in_ready_o never sees out_ready_i.
  assign empty_o    = (count_reg == '0);
  assign full_o     = (count_reg == CNT_W'(DEPTH));
  assign in_ready_o = !full_o;
  assign count_o    = count_reg;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  assign out_valid_o     = !empty_o && !hazard;
  assign hazard_stall_o  = !empty_o && hazard;
  assign out_pc_o        = head.pc;
  assign out_payload_o   = head.payload;
  assign out_rd_o        = head.rd;
  assign out_reg_write_o = head.reg_write;

  // Pointer/occupancy next state; flush overrides any same-cycle push or pop.
  always_comb begin
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    if (flush_i) begin
      rptr_next  = '0;
      wptr_next  = '0;
      count_next = '0;
    end else begin
      if (push) wptr_next = wptr_reg + PTR_W'(1);
      if (pop)  rptr_next = rptr_reg + PTR_W'(1);
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (pop && !push) count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
    end
  end

  // Entry storage; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wptr_reg] <= entry_in;
  end

  issue_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .rs1_i       (head.rs1),
    .rs2_i       (head.rs2),
    .rs1_use_i   (head.rs1_use),
    .rs2_use_i   (head.rs2_use),
    .rd_i        (head.rd),
    .reg_write_i (head.reg_write),
    .issue_i     (pop),
    .wb_write_i  (wb_write_i),
    .wb_rd_i     (wb_rd_i),
    .hazard_o    (hazard)
  );

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed bench for decode_issue_buffer (DEPTH=4): fill/drain, wrap,
// RAW/WAW/x0 hazards, same-cycle set/clear, flush and async reset.
module tb_decode_issue_buffer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_pc_i;
  logic [127:0] in_payload_i;
  logic [4:0]   in_rs1_i, in_rs2_i, in_rd_i;
  logic         in_rs1_use_i, in_rs2_use_i, in_reg_write_i;
  logic         out_valid_o, out_ready_i;
  logic [31:0]  out_pc_o;
  logic [127:0] out_payload_o;
  logic [4:0]   out_rd_o;
  logic         out_reg_write_o;
  logic         wb_write_i;
  logic [4:0]   wb_rd_i;
  logic         flush_i;
  logic [2:0]   count_o;
  logic         empty_o, full_o, hazard_stall_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  decode_issue_buffer #(.DEPTH(4), .XLEN(32), .PAYLOAD_W(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
    .in_payload_i(in_payload_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
    .in_rs1_use_i(in_rs1_use_i), .in_rs2_use_i(in_rs2_use_i), .in_rd_i(in_rd_i),
    .in_reg_write_i(in_reg_write_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_payload_o(out_payload_o), .out_rd_o(out_rd_o),
    .out_reg_write_o(out_reg_write_o), .wb_write_i(wb_write_i), .wb_rd_i(wb_rd_i),
    .flush_i(flush_i), .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .hazard_stall_o(hazard_stall_o)
  );

  // Advance to one time unit after the next falling edge.
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw);
    in_valid_i     = v;
    in_pc_i        = pc;
    in_payload_i   = {4{pc ^ 32'hA5A5_0000}};
    in_rs1_i       = rs1;
    in_rs1_use_i   = u1;
    in_rs2_i       = rs2;
    in_rs2_use_i   = u2;
    in_rd_i        = rd;
    in_reg_write_i = rw;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; out_ready_i = 1'b0; wb_write_i = 1'b0; wb_rd_i = '0; flush_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #2;
    tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty_o); end
    tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full_o); end
    tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
    tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready_o); end
    tests++; if (hazard_stall_o !== 1'b0) begin fails++; $display("FAIL reset_hazard got %b exp 0", hazard_stall_o); end
    tick(); tick();
    rst_i = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_fill_drain();
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b1, 32'h100 + 32'(4 * i), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL fill_in_ready[%0d] got %b exp 1", i, in_ready_o); end
      if (i == 0) begin
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL no_bypass got %b exp 0", out_valid_o); end
      end
    end
    tick();
    in_valid_i = 1'b0;
    #1;
    tests++; if (full_o !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", full_o); end
    tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL fill_in_ready_full got %b exp 0", in_ready_o); end
    tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", count_o); end
    tests++; if (out_pc_o !== 32'h100) begin fails++; $display("FAIL fill_head_pc got %h exp 100", out_pc_o); end
    // Push while full with a same-cycle pop must still be refused.
    drive(1'b1, 32'h1F0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    out_ready_i = 1'b1;
    #1;
    tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL full_pop_in_ready got %b exp 0", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    #1;
    tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL full_pop_count got %0d exp 3", count_o); end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (out_valid_o !== 1'b1 || out_pc_o !== 32'h100 + 32'(4 * i)) begin
        fails++; $display("FAIL drain[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid_o, out_pc_o, 32'h100 + 32'(4 * i));
      end
      tests++;
      if (out_payload_o !== {4{(32'h100 + 32'(4 * i)) ^ 32'hA5A5_0000}}) begin
        fails++; $display("FAIL drain_payload[%0d] got %h", i, out_payload_o);
      end
      tick(); #1;
    end
    tests++; if (empty_o !== 1'b1 || out_valid_o !== 1'b0 || count_o !== 3'd0) begin
      fails++; $display("FAIL drain_empty got e=%b v=%b c=%0d exp e=1 v=0 c=0", empty_o, out_valid_o, count_o);
    end
    $display("[TB] fill/drain checked");
  endtask

  task automatic test_wrap();
    out_ready_i = 1'b0;
    tick(); drive(1'b1, 32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); drive(1'b1, 32'h304, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 2; k < 12; k++) begin
      tick();
      drive(1'b1, 32'h300 + 32'(4 * k), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      out_ready_i = 1'b1;
      #1;
      tests++;
      if (count_o !== 3'd2 || out_valid_o !== 1'b1 || out_pc_o !== 32'h300 + 32'(4 * (k - 2))) begin
        fails++; $display("FAIL wrap[%0d] got c=%0d v=%b pc=%h exp c=2 v=1 pc=%h",
                          k, count_o, out_valid_o, out_pc_o, 32'h300 + 32'(4 * (k - 2)));
      end
    end
    tick(); in_valid_i = 1'b0; #1;
    tests++; if (out_pc_o !== 32'h328) begin fails++; $display("FAIL wrap_tail0 got %h exp 328", out_pc_o); end
    tick(); #1;
    tests++; if (out_pc_o !== 32'h32C) begin fails++; $display("FAIL wrap_tail1 got %h exp 32c", out_pc_o); end
    tick(); #1;
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", empty_o); end
    $display("[TB] wrap checked");
  endtask

  task automatic test_raw();
    out_ready_i = 1'b1;
    tick(); drive(1'b1, 32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick(); drive(1'b1, 32'h404, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    tests++; if (out_valid_o !== 1'b1 || out_rd_o !== 5'd5 || out_reg_write_o !== 1'b1) begin
      fails++; $display("FAIL raw_writer got v=%b rd=%0d rw=%b exp v=1 rd=5 rw=1", out_valid_o, out_rd_o, out_reg_write_o);
    end
    tick(); in_valid_i = 1'b0; #1;
    tests++; if (hazard_stall_o !== 1'b1 || out_valid_o !== 1'b0 || out_pc_o !== 32'h404) begin
      fails++; $display("FAIL raw_stall got h=%b v=%b pc=%h exp h=1 v=0 pc=404", hazard_stall_o, out_valid_o, out_pc_o);
    end
    tick(); #1;
    tests++; if (hazard_stall_o !== 1'b1) begin fails++; $display("FAIL raw_stall_hold got %b exp 1", hazard_stall_o); end
    wb_write_i = 1'b1; wb_rd_i = 5'd5; #1;
    tests++; if (out_valid_o !== 1'b1 || hazard_stall_o !== 1'b0) begin
      fails++; $display("FAIL raw_wb_release got v=%b h=%b exp v=1 h=0", out_valid_o, hazard_stall_o);
    end
    tick(); wb_write_i = 1'b0; #1;
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL raw_empty got %b exp 1", empty_o); end
    $display("[TB] raw checked");
  endtask

  task automatic test_x0_waw();
    out_ready_i = 1'b1;
    tick(); drive(1'b1, 32'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick(); drive(1'b1, 32'h504, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    tick(); drive(1'b1, 32'h508, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
    tests++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h504) begin
      fails++; $display("FAIL x0_reader got v=%b pc=%h exp v=1 pc=504", out_valid_o, out_pc_o);
    end
    tick(); drive(1'b1, 32'h50C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick(); in_valid_i = 1'b0; #1;
    tests++; if (hazard_stall_o !== 1'b1 || out_pc_o !== 32'h50C) begin
      fails++; $display("FAIL waw_stall got h=%b pc=%h exp h=1 pc=50c", hazard_stall_o, out_pc_o);
    end
    wb_write_i = 1'b1; wb_rd_i = 5'd6; #1;
    tests++; if (hazard_stall_o !== 1'b1) begin fails++; $display("FAIL waw_other_wb got %b exp 1", hazard_stall_o); end
    wb_rd_i = 5'd7; #1;
    tests++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL waw_release got %b exp 1", out_valid_o); end
    tick(); wb_rd_i = 5'd7; #1;
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL waw_empty got %b exp 1", empty_o); end
    tick(); wb_write_i = 1'b0; #1;
    $display("[TB] x0/waw checked");
  endtask

  task automatic test_same_cycle();
    out_ready_i = 1'b1;
    tick(); drive(1'b1, 32'h600, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    tick(); drive(1'b1, 32'h604, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    wb_write_i = 1'b1; wb_rd_i = 5'd3; #1;
    tests++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h600) begin
      fails++; $display("FAIL setclr_writer got v=%b pc=%h exp v=1 pc=600", out_valid_o, out_pc_o);
    end
    tick(); in_valid_i = 1'b0; wb_write_i = 1'b0; #1;
    tests++; if (hazard_stall_o !== 1'b1 || out_pc_o !== 32'h604) begin
      fails++; $display("FAIL setclr_stall got h=%b pc=%h exp h=1 pc=604", hazard_stall_o, out_pc_o);
    end
    wb_write_i = 1'b1; wb_rd_i = 5'd3; #1;
    tests++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL setclr_release got %b exp 1", out_valid_o); end
    tick(); wb_write_i = 1'b0; #1;
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL setclr_empty got %b exp 1", empty_o); end
    $display("[TB] same-cycle set/clear checked");
  endtask

  task automatic test_flush();
    out_ready_i = 1'b1;
    tick(); drive(1'b1, 32'h700, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick(); drive(1'b1, 32'h704, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); drive(1'b1, 32'h708, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); drive(1'b1, 32'h70C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); in_valid_i = 1'b0; #1;
    tests++; if (count_o !== 3'd3 || hazard_stall_o !== 1'b1) begin
      fails++; $display("FAIL flush_setup got c=%0d h=%b exp c=3 h=1", count_o, hazard_stall_o);
    end
    flush_i = 1'b1;
    drive(1'b1, 32'h777, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); flush_i = 1'b0;
    drive(1'b1, 32'h780, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    tests++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin
      fails++; $display("FAIL flush_empty got c=%0d e=%b exp c=0 e=1", count_o, empty_o);
    end
    tick(); in_valid_i = 1'b0; #1;
    tests++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h780 || count_o !== 3'd1) begin
      fails++; $display("FAIL flush_after got v=%b pc=%h c=%0d exp v=1 pc=780 c=1", out_valid_o, out_pc_o, count_o);
    end
    tick(); #1;
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL flush_drain got %b exp 1", empty_o); end
    $display("[TB] flush checked");
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b1;
    tick(); drive(1'b1, 32'h800, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    tick(); drive(1'b1, 32'h804, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); drive(1'b1, 32'h808, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); in_valid_i = 1'b0; #1;
    tests++; if (count_o !== 3'd2 || hazard_stall_o !== 1'b1) begin
      fails++; $display("FAIL arst_setup got c=%0d h=%b exp c=2 h=1", count_o, hazard_stall_o);
    end
    rst_i = 1'b0; #1;
    tests++; if (count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      fails++; $display("FAIL arst_state got c=%0d e=%b f=%b exp c=0 e=1 f=0", count_o, empty_o, full_o);
    end
    tests++; if (out_valid_o !== 1'b0 || hazard_stall_o !== 1'b0 || in_ready_o !== 1'b1) begin
      fails++; $display("FAIL arst_outs got v=%b h=%b r=%b exp v=0 h=0 r=1", out_valid_o, hazard_stall_o, in_ready_o);
    end
    tick(); rst_i = 1'b1;
    drive(1'b1, 32'h810, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); in_valid_i = 1'b0; #1;
    tests++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h810) begin
      fails++; $display("FAIL arst_pend_cleared got v=%b pc=%h exp v=1 pc=810", out_valid_o, out_pc_o);
    end
    tick(); #1;
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL arst_drain got %b exp 1", empty_o); end
    $display("[TB] async reset checked");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_raw();
    test_x0_waw();
    test_same_cycle();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
